// File: rtl/result_serializer.sv
// Result serializer: snapshots five result registers and streams them as a
// 19-byte framed message (header, payload, flag, XOR checksum) over valid/ready.
module result_serializer #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             snap_i,
  input  logic [31:0]      attempt_count_i,
  input  logic [31:0]      broken_count_i,
  input  logic             last_broken_i,
  input  logic [31:0]      cost_f1_i,
  input  logic [31:0]      cost_f2_i,
  output logic             tx_valid_o,
  output logic [7:0]       tx_data_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_attempt, r_broken, r_f1, r_f2;
  logic             r_last;
  logic [4:0]       r_idx;
  logic [7:0]       r_csum;
  logic             r_pend;
  logic [CNT_W-1:0] r_frame_cnt, r_drop_cnt;

  logic       w_start, w_accept, w_last_byte;
  logic [4:0] w_off;
  logic [31:0] w_word;
  logic [7:0] w_field_byte, w_byte;

  assign w_start     = (r_state == IDLE) && (snap_i || r_pend);
  assign w_accept    = (r_state == SEND) && tx_ready_i;
  assign w_last_byte = (r_idx == 5'd18);

  // Payload bytes 1..16 are four 32-bit words, each sent MSB first.
  assign w_off = r_idx - 5'd1;
  always_comb begin
    w_word = r_attempt;
    case (w_off[3:2])
      2'd0: w_word = r_attempt;
      2'd1: w_word = r_broken;
      2'd2: w_word = r_f1;
      2'd3: w_word = r_f2;
      default: w_word = r_attempt;
    endcase
  end
  assign w_field_byte = w_word[{~w_off[1:0], 3'b000} +: 8];

  always_comb begin
    w_byte = r_csum;
    if (r_idx == 5'd0)        w_byte = HEADER;
    else if (r_idx <= 5'd16)  w_byte = w_field_byte;
    else if (r_idx == 5'd17)  w_byte = {7'b0, r_last};
    else                      w_byte = r_csum;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = SEND;
      SEND:    if (w_accept && w_last_byte) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    tx_valid_o = (r_state == SEND);
    tx_data_o  = (r_state == SEND) ? w_byte : 8'h00;
    busy_o     = (r_state != IDLE);
    done_o     = (r_state == DONE);
  end

  // Shadow copies are loaded only at the start edge so the frame in flight is frozen.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_attempt <= '0;
      r_broken  <= '0;
      r_f1      <= '0;
      r_f2      <= '0;
      r_last    <= 1'b0;
      r_idx     <= '0;
      r_csum    <= '0;
    end else if (w_start) begin
      r_attempt <= attempt_count_i;
      r_broken  <= broken_count_i;
      r_f1      <= cost_f1_i;
      r_f2      <= cost_f2_i;
      r_last    <= last_broken_i;
      r_idx     <= '0;
      r_csum    <= '0;
    end else if (w_accept && !w_last_byte) begin
      r_idx  <= r_idx + 5'd1;
      r_csum <= r_csum ^ w_byte;
    end
  end

  // A snap during a frame is remembered once; further snaps are only counted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pend      <= 1'b0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_start) begin
        r_pend <= 1'b0;
      end else if (snap_i && (r_state != IDLE)) begin
        if (!r_pend)                r_pend     <= 1'b1;
        else if (r_drop_cnt != '1)  r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
      if (w_accept && w_last_byte) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  assign frame_cnt_o = r_frame_cnt;
  assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: table of frames with hand-computed
// checksums, plus pending-merge, mid-frame reset, wrap and saturation sequences.
module tb_result_serializer;

  logic        clk = 1'b0;
  logic        rst_n, snap, ready, last;
  logic [31:0] att, brk, f1, f2;
  logic        txValid, busy, done;
  logic [7:0]  txData;
  logic [15:0] frameCnt, dropCnt;
  logic        txValidN, busyN, doneN;
  logic [7:0]  txDataN;
  logic [3:0]  frameCntN, dropCntN;

  always #5 clk = ~clk;

  result_serializer dut (
    .clk_i(clk), .rst_n_i(rst_n), .snap_i(snap),
    .attempt_count_i(att), .broken_count_i(brk), .last_broken_i(last),
    .cost_f1_i(f1), .cost_f2_i(f2),
    .tx_valid_o(txValid), .tx_data_o(txData), .tx_ready_i(ready),
    .busy_o(busy), .done_o(done), .frame_cnt_o(frameCnt), .drop_cnt_o(dropCnt)
  );

  // Narrow-counter copy so counter wrap and saturation are reachable quickly.
  result_serializer #(.CNT_W(4)) dutN (
    .clk_i(clk), .rst_n_i(rst_n), .snap_i(snap),
    .attempt_count_i(att), .broken_count_i(brk), .last_broken_i(last),
    .cost_f1_i(f1), .cost_f2_i(f2),
    .tx_valid_o(txValidN), .tx_data_o(txDataN), .tx_ready_i(ready),
    .busy_o(busyN), .done_o(doneN), .frame_cnt_o(frameCntN), .drop_cnt_o(dropCntN)
  );

  typedef struct {
    logic [31:0] att;
    logic [31:0] brk;
    logic [31:0] f1;
    logic [31:0] f2;
    logic        last;
    logic [7:0]  csum;
    logic        toggle;
  } vec_t;

  vec_t       vecs[5];
  vec_t       pendVec;
  logic [7:0] expBytes[19];
  int         applied = 0;
  int         miscompares = 0;
  int         hsCount = 0;
  int         expFrames = 0;

  always @(posedge clk) if (txValid && ready) hsCount <= hsCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    att  = v.att;
    brk  = v.brk;
    f1   = v.f1;
    f2   = v.f2;
    last = v.last;
  endtask

  task automatic buildFrame(input vec_t v);
    expBytes[0] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      expBytes[1 + i]  = v.att[31 - 8*i -: 8];
      expBytes[5 + i]  = v.brk[31 - 8*i -: 8];
      expBytes[9 + i]  = v.f1[31 - 8*i -: 8];
      expBytes[13 + i] = v.f2[31 - 8*i -: 8];
    end
    expBytes[17] = {7'b0, v.last};
    expBytes[18] = v.csum;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic runFrame(input vec_t v, input bit doSnap, input bit toggle,
                          input logic [31:0] snapMask, input int changeAt, input int stallSnap);
    int         idx, cyc, hsStart;
    logic       stalled, r;
    logic [7:0] prevData;
    buildFrame(v);
    if (doSnap) begin
      applyStimulus(v);
      snap = 1'b1;
    end
    tick;
    snap = 1'b0;
    checkOutput("first_valid", 32'(txValid), 32'd1);
    hsStart = hsCount;
    if (stallSnap > 0) begin
      ready = 1'b0;
      snap  = 1'b1;
      repeat (stallSnap) begin
        tick;
        checkOutput("stall_header", 32'(txData), 32'hA5);
      end
      snap = 1'b0;
    end
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    prevData = 8'h00;
    while (idx < 19 && cyc < 100) begin
      if (stalled) checkOutput("stall_stable", 32'(txData), 32'(prevData));
      checkOutput("valid_held", 32'(txValid), 32'd1);
      r = toggle ? (cyc % 2 == 0) : 1'b1;
      ready = r;
      snap = snapMask[idx];
      if (idx == changeAt) att = 32'h7;
      if (r) begin
        checkOutput($sformatf("byte%0d", idx), 32'(txData), 32'(expBytes[idx]));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prevData = txData;
      end
      tick;
      cyc++;
    end
    snap = 1'b0;
    if (idx < 19) checkOutput("frame_timeout", 32'(idx), 32'd19);
    expFrames++;
    checkOutput("handshakes", 32'(hsCount - hsStart), 32'd19);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_valid", 32'(txValid), 32'd0);
    checkOutput("frame_cnt", 32'(frameCnt), 32'(expFrames % 65536));
    checkOutput("frame_cnt_n", 32'(frameCntN), 32'(expFrames % 16));
    tick;
    checkOutput("done_width", 32'(done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{32'd3,         32'd1,         32'h10,        32'h20,        1'b1, 8'h96, 1'b0};
    vecs[1] = '{32'd0,         32'd0,         32'd0,         32'd0,         1'b0, 8'hA5, 1'b0};
    vecs[2] = '{32'd3,         32'd1,         32'h10,        32'h20,        1'b1, 8'h96, 1'b1};
    vecs[3] = '{32'h12345678,  32'h9ABCDEF0,  32'h0F0F0F0F,  32'hF0F0F0F0,  1'b1, 8'hA4, 1'b0};
    vecs[4] = '{32'hDEADBEEF,  32'd0,         32'd1,         32'h80000000,  1'b0, 8'h06, 1'b1};
    pendVec = '{32'd7,         32'd1,         32'h10,        32'h20,        1'b1, 8'h92, 1'b0};

    rst_n = 1'b0;
    snap  = 1'b0;
    ready = 1'b0;
    applyStimulus(vecs[1]);
    #12;
    checkOutput("rst_valid", 32'(txValid), 32'd0);
    checkOutput("rst_data", 32'(txData), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frameCnt), 32'd0);
    checkOutput("rst_drop_cnt", 32'(dropCnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick;
    checkOutput("idle_wait", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) runFrame(vecs[i], 1'b1, vecs[i].toggle, 32'h0, -1, 0);

    // Snap at byte 5, attempt changed at byte 10, three merged snaps at 12..14.
    runFrame(vecs[0], 1'b1, 1'b0, 32'h0000_7020, 10, 0);
    runFrame(pendVec, 1'b0, 1'b0, 32'h0, -1, 0);
    checkOutput("drop_cnt_merge", 32'(dropCnt), 32'd3);
    checkOutput("drop_cnt_merge_n", 32'(dropCntN), 32'd3);

    // Reset in the middle of a frame.
    applyStimulus(vecs[0]);
    snap = 1'b1;
    tick;
    snap = 1'b0;
    ready = 1'b1;
    repeat (12) tick;
    checkOutput("pre_reset_valid", 32'(txValid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(txValid), 32'd0);
    checkOutput("abort_data", 32'(txData), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_frame_cnt", 32'(frameCnt), 32'd0);
    checkOutput("abort_drop_cnt", 32'(dropCnt), 32'd0);
    expFrames = 0;
    tick;
    tick;
    checkOutput("abort_no_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick;
    checkOutput("post_reset_idle", 32'(busy), 32'd0);
    checkOutput("post_reset_no_done", 32'(done), 32'd0);
    runFrame(vecs[0], 1'b1, 1'b0, 32'h0, -1, 0);

    for (int i = 0; i < 15; i++) runFrame(vecs[1], 1'b1, 1'b0, 32'h0, -1, 0);
    checkOutput("frame_wrap_n", 32'(frameCntN), 32'd0);
    checkOutput("frame_16", 32'(frameCnt), 32'd16);

    // Twenty stalled snaps: one becomes pending, nineteen are counted as drops.
    runFrame(vecs[1], 1'b1, 1'b0, 32'h0, -1, 20);
    checkOutput("drop_cnt_19", 32'(dropCnt), 32'd19);
    checkOutput("drop_sat_n", 32'(dropCntN), 32'hF);
    runFrame(vecs[1], 1'b0, 1'b0, 32'h0, -1, 0);
    checkOutput("drop_hold", 32'(dropCnt), 32'd19);
    checkOutput("drop_hold_n", 32'(dropCntN), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
